// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    // Handshake state encoding; the value doubles as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    // RV32 NOP (addi x0, x0, 0) used as the IF/ID bubble payload.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Entries held for a given state.
    function automatic logic [OCC_W-1:0] occ_of(input state_t s);
        return OCC_W'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Valid/ready handshake controller for one elastic pipeline stage.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter bit SKID = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OCC_W-1:0] occupancy,
    output logic             load_main_c,
    output logic             load_skid_c,
    output logic             skid_to_main_c,
    output logic             clear_main_c
);

    state_t           state_q;
    logic             out_valid_q;
    logic [OCC_W-1:0] occ_q;
    logic             rdy_q;
    logic             acc_c;
    logic             dlv_c;

    assign out_valid = out_valid_q;
    assign occupancy = occ_q;
    assign acc_c     = in_valid & in_ready;
    assign dlv_c     = out_valid_q & out_ready;

    // Ready: from state alone with the skid buffer, otherwise straight from downstream.
    if (SKID) begin : g_rdy_skid
        assign in_ready = reset_n & rdy_q;
    end else begin : g_rdy_comb
        logic unused_rdy;
        assign unused_rdy = rdy_q;
        assign in_ready   = reset_n & (~out_valid_q | out_ready);
    end

    // Handshake state machine with registered status outputs.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            occ_q       <= occ_of(ST_EMPTY);
            rdy_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_c) begin
                        state_q     <= ST_FULL;
                        out_valid_q <= 1'b1;
                        occ_q       <= occ_of(ST_FULL);
                    end
                end
                ST_FULL: begin
                    if (acc_c && !dlv_c) begin
                        state_q <= ST_SKID;
                        occ_q   <= occ_of(ST_SKID);
                        rdy_q   <= 1'b0;
                    end else if (!acc_c && dlv_c) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                        occ_q       <= occ_of(ST_EMPTY);
                    end
                end
                ST_SKID: begin
                    if (dlv_c) begin
                        state_q <= ST_FULL;
                        occ_q   <= occ_of(ST_FULL);
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    occ_q       <= occ_of(ST_EMPTY);
                    rdy_q       <= 1'b1;
                end
            endcase
        end
    end

    // Datapath strobes for the main and skid registers.
    always_comb begin
        load_main_c    = 1'b0;
        load_skid_c    = 1'b0;
        skid_to_main_c = 1'b0;
        clear_main_c   = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: load_main_c = acc_c;
                ST_FULL: begin
                    load_main_c  = acc_c & dlv_c;
                    load_skid_c  = acc_c & ~dlv_c;
                    clear_main_c = ~acc_c & dlv_c;
                end
                ST_SKID:  skid_to_main_c = dlv_c;
                default:  clear_main_c = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline register: opaque payload under valid/ready, optional skid, flush, bypass.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter bit               BYPASS       = 1'b0,
    parameter bit               SKID         = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    if (BYPASS) begin : g_bypass
        logic unused_ctl;
        assign unused_ctl = ^{clock, reset_n, flush};
        assign out_valid  = in_valid;
        assign out_data   = in_data;
        assign in_ready   = out_ready;
        assign occupancy  = '0;
    end else begin : g_reg
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;
        logic             load_main_c;
        logic             load_skid_c;
        logic             skid_to_main_c;
        logic             clear_main_c;

        pipe_stage_ctrl #(
            .SKID (SKID)
        ) u_ctrl (
            .clock          (clock),
            .reset_n        (reset_n),
            .flush          (flush),
            .in_valid       (in_valid),
            .out_ready      (out_ready),
            .in_ready       (in_ready),
            .out_valid      (out_valid),
            .occupancy      (occupancy),
            .load_main_c    (load_main_c),
            .load_skid_c    (load_skid_c),
            .skid_to_main_c (skid_to_main_c),
            .clear_main_c   (clear_main_c)
        );

        // Main register drives out_data; it holds the bubble whenever the stage is empty.
        always_ff @(posedge clock) begin
            if (!reset_n || flush) begin
                main_q <= BUBBLE_VALUE;
            end else if (load_main_c) begin
                main_q <= in_data;
            end else if (skid_to_main_c) begin
                main_q <= skid_q;
            end else if (clear_main_c) begin
                main_q <= BUBBLE_VALUE;
            end
        end

        // Skid register catches the beat accepted while downstream stalls.
        always_ff @(posedge clock) begin
            if (!reset_n || flush) begin
                skid_q <= BUBBLE_VALUE;
            end else if (load_skid_c) begin
                skid_q <= in_data;
            end
        end

        assign out_data = main_q;
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: skid build with NOP bubble, plus SKID=0 and BYPASS builds.
module tb_pipe_stage;
    import pipe_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;

    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0] in_data0, out_data0;
    logic [1:0]  occ0;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [15:0] in_data_b, out_data_b;
    logic [1:0]  occ_b;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    pipe_stage #(.WIDTH(32), .BYPASS(1'b0), .SKID(1'b1), .BUBBLE_VALUE(NOP)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage #(.WIDTH(32), .BYPASS(1'b0), .SKID(1'b0), .BUBBLE_VALUE(NOP)) dut0 (
        .clock(clock), .reset_n(reset_n), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .occupancy(occ0)
    );

    pipe_stage #(.WIDTH(16), .BYPASS(1'b1), .SKID(1'b1)) dutb (
        .clock(clock), .reset_n(reset_n), .flush(flush0),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .occupancy(occ_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    // Monitor: pop on each delivered beat, push on each accepted beat, drop on flush/reset.
    always @(negedge clock) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %h, expected no beat at %0t", out_data, $time);
            end else begin
                chk("sb_data", out_data, exp_q.pop_front());
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(in_data);
        if (flush === 1'b1 || reset_n === 1'b0) exp_q.delete();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA_AAAA; out_ready = 1'b1;
        flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;

        // Reset held for three edges with a beat presented
        repeat (3) tick();
        mid();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, NOP);
        chk("rst_occ", 32'(occupancy), 32'd0);
        tick(); reset_n = 1'b1; in_valid = 1'b0;
        mid();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_occ", 32'(occupancy), 32'd0);

        // Back-to-back stream 1..8, one beat per cycle, no gaps
        for (int i = 1; i <= 8; i++) begin
            tick(); in_valid = 1'b1; in_data = 32'(i);
            mid();
            chk("stream_valid", 32'(out_valid), 32'(i > 1));
            if (i > 1) chk("stream_data", out_data, 32'(i - 1));
        end
        tick(); in_valid = 1'b0;
        mid();
        chk("stream_last", out_data, 32'd8);
        tick(); mid();
        chk("stream_drained", 32'(out_valid), 32'd0);
        chk("stream_bubble", out_data, NOP);

        // Backpressure after 0x3 is accepted
        tick(); in_valid = 1'b1; in_data = 32'h3; out_ready = 1'b1;
        mid();
        chk("bp_rdy_empty", 32'(in_ready), 32'd1);
        tick(); in_data = 32'h4; out_ready = 1'b0;
        mid();
        chk("bp_hold3", out_data, 32'h3);
        chk("bp_occ1", 32'(occupancy), 32'd1);
        tick(); in_data = 32'h5;
        mid();
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_rdy0", 32'(in_ready), 32'd0);
        chk("bp_still3", out_data, 32'h3);
        tick(); mid();
        chk("bp_hold_occ2", 32'(occupancy), 32'd2);
        tick(); out_ready = 1'b1;
        mid();
        chk("bp_out3", out_data, 32'h3);
        tick(); mid();
        chk("bp_out4", out_data, 32'h4);
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        chk("bp_occ_back1", 32'(occupancy), 32'd1);
        tick(); in_valid = 1'b0;
        mid();
        chk("bp_out5", out_data, 32'h5);
        tick(); mid();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Flush with both entries held
        tick(); in_valid = 1'b1; in_data = 32'h10; out_ready = 1'b0;
        mid();
        tick(); in_data = 32'h11;
        mid();
        tick(); in_data = 32'h12; flush = 1'b1;
        mid();
        chk("fl_pre_occ2", 32'(occupancy), 32'd2);
        tick(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mid();
        chk("fl_occ0", 32'(occupancy), 32'd0);
        chk("fl_valid0", 32'(out_valid), 32'd0);
        chk("fl_bubble", out_data, NOP);
        chk("fl_rdy", 32'(in_ready), 32'd1);

        // Flush while a beat is accepted and another delivered
        tick(); in_valid = 1'b1; in_data = 32'h20; out_ready = 1'b0;
        mid();
        tick(); in_data = 32'h77; out_ready = 1'b1; flush = 1'b1;
        mid();
        chk("fl2_out20", out_data, 32'h20);
        tick(); flush = 1'b0; in_valid = 1'b0;
        mid();
        chk("fl2_valid0", 32'(out_valid), 32'd0);
        chk("fl2_occ0", 32'(occupancy), 32'd0);
        tick(); mid();
        chk("fl2_no77", 32'(out_valid), 32'd0);

        // Simultaneous flush and reset with both entries held
        tick(); in_valid = 1'b1; in_data = 32'h30; out_ready = 1'b0;
        mid();
        tick(); in_data = 32'h31;
        mid();
        tick(); in_valid = 1'b0;
        mid();
        chk("fr_pre_occ2", 32'(occupancy), 32'd2);
        tick(); reset_n = 1'b0; flush = 1'b1;
        mid();
        chk("fr_rdy_in_rst", 32'(in_ready), 32'd0);
        tick(); reset_n = 1'b1; flush = 1'b0;
        mid();
        chk("fr_occ0", 32'(occupancy), 32'd0);
        chk("fr_valid0", 32'(out_valid), 32'd0);
        chk("fr_bubble", out_data, NOP);
        chk("fr_rdy1", 32'(in_ready), 32'd1);

        // Flush while empty changes nothing
        tick(); flush = 1'b1;
        mid();
        tick(); flush = 1'b0;
        mid();
        chk("fe_occ0", 32'(occupancy), 32'd0);
        chk("fe_valid0", 32'(out_valid), 32'd0);
        chk("fe_bubble", out_data, NOP);
        chk("fe_rdy1", 32'(in_ready), 32'd1);

        // SKID=0: in_ready follows out_ready combinationally when full
        tick(); out_ready0 = 1'b0;
        mid();
        chk("s0_rdy_empty", 32'(in_ready0), 32'd1);
        tick(); in_valid0 = 1'b1; in_data0 = 32'h55;
        mid();
        tick(); in_valid0 = 1'b0;
        mid();
        chk("s0_data55", out_data0, 32'h55);
        chk("s0_occ1", 32'(occ0), 32'd1);
        chk("s0_rdy_stall", 32'(in_ready0), 32'd0);
        #1 out_ready0 = 1'b1;
        #1 chk("s0_rdy_comb", 32'(in_ready0), 32'd1);
        tick(); in_valid0 = 1'b1; in_data0 = 32'h56;
        mid();
        chk("s0_drained", 32'(out_valid0), 32'd0);
        tick(); in_data0 = 32'h57;
        mid();
        chk("s0_data56", out_data0, 32'h56);
        chk("s0_rdy_full", 32'(in_ready0), 32'd1);
        tick(); in_valid0 = 1'b0;
        mid();
        chk("s0_data57", out_data0, 32'h57);

        // BYPASS: pure wires
        in_valid_b = 1'b1; in_data_b = 16'h1234; out_ready_b = 1'b0;
        #1;
        chk("by_valid", 32'(out_valid_b), 32'd1);
        chk("by_data", 32'(out_data_b), 32'h1234);
        chk("by_rdy0", 32'(in_ready_b), 32'd0);
        chk("by_occ", 32'(occ_b), 32'd0);
        out_ready_b = 1'b1;
        #1 chk("by_rdy1", 32'(in_ready_b), 32'd1);
        in_data_b = 16'hBEEF; in_valid_b = 1'b0;
        #1;
        chk("by_data2", 32'(out_data_b), 32'hBEEF);
        chk("by_valid0", 32'(out_valid_b), 32'd0);

        tick(); mid();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
